// File: rtl/sm_fxp_divider_pkg.sv
// Shared constants and types for the sign-magnitude Q0.16 divider.
package sm_fxp_divider_pkg;

  localparam int DATA_WIDTH = 17;
  localparam int MAG_WIDTH  = DATA_WIDTH - 1;
  localparam int REM_WIDTH  = MAG_WIDTH + 2;
  localparam int Q_WIDTH    = MAG_WIDTH + 1;
  localparam int DIV_ITERS  = Q_WIDTH;
  localparam int CNT_WIDTH  = 5;

  localparam logic [MAG_WIDTH-1:0] MAG_MAX = 16'hFFFF;

  typedef struct packed {
    logic                 sign;
    logic [MAG_WIDTH-1:0] mag;
  } sm_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/sm_restoring_div_step.sv
// One restoring-division iteration: shift the remainder, subtract the divisor if it fits.
module sm_restoring_div_step
  import sm_fxp_divider_pkg::*;
(
  input  logic [REM_WIDTH-1:0] i_rem,
  input  logic [MAG_WIDTH-1:0] i_divisor,
  output logic [REM_WIDTH-1:0] o_rem,
  output logic                 o_q_bit
);

  logic [REM_WIDTH-1:0] w_shifted;
  logic [REM_WIDTH-1:0] w_divisor_ext;

  assign w_shifted     = {i_rem[REM_WIDTH-2:0], 1'b0};
  assign w_divisor_ext = {2'b00, i_divisor};
  assign o_q_bit       = (w_shifted >= w_divisor_ext);
  assign o_rem         = o_q_bit ? (w_shifted - w_divisor_ext) : w_shifted;

endmodule

// File: rtl/sm_fxp_divider.sv
// Iterative sign-magnitude Q0.16 divider with round-half-up, saturation and divide-by-zero flag.
module sm_fxp_divider
  import sm_fxp_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic                  saturated,
  output logic                  div_by_zero
);

  div_state_t           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [REM_WIDTH-1:0] r_rem;
  logic [Q_WIDTH-1:0]   r_q17;
  logic [MAG_WIDTH-1:0] r_b;
  logic                 r_sign;
  logic                 r_dividend_sign;
  logic                 r_zero_div;
  logic                 r_ge;
  logic                 r_out_valid;
  sm_word_t             r_quotient;
  logic                 r_saturated;
  logic                 r_div_by_zero;

  logic                 w_accept;
  logic [REM_WIDTH-1:0] w_rem_next;
  logic                 w_q_bit;
  logic [MAG_WIDTH:0]   w_round_sum;
  sm_word_t             w_result;
  logic                 w_res_sat;
  logic                 w_res_dbz;

  assign in_ready    = (r_state == IDLE);
  assign w_accept    = in_valid & in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign saturated   = r_saturated;
  assign div_by_zero = r_div_by_zero;

  sm_restoring_div_step u_step (
    .i_rem     (r_rem),
    .i_divisor (r_b),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  assign w_round_sum = {1'b0, r_q17[Q_WIDTH-1:1]} + {{MAG_WIDTH{1'b0}}, r_q17[0]};

  // Special cases take priority over the iterated result; zero divisor wins even for 0/0.
  always_comb begin
    w_result.sign = r_sign;
    w_result.mag  = MAG_MAX;
    w_res_sat     = 1'b0;
    w_res_dbz     = 1'b0;
    if (r_zero_div) begin
      w_result.sign = r_dividend_sign;
      w_res_dbz     = 1'b1;
    end else if (r_ge || w_round_sum[MAG_WIDTH]) begin
      w_res_sat = 1'b1;
    end else begin
      w_result.mag  = w_round_sum[MAG_WIDTH-1:0];
      w_result.sign = r_sign & (|w_round_sum[MAG_WIDTH-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_rem           <= '0;
      r_q17           <= '0;
      r_b             <= '0;
      r_sign          <= 1'b0;
      r_dividend_sign <= 1'b0;
      r_zero_div      <= 1'b0;
      r_ge            <= 1'b0;
      r_out_valid     <= 1'b0;
      r_quotient      <= '0;
      r_saturated     <= 1'b0;
      r_div_by_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state         <= DIV;
            r_cnt           <= '0;
            r_rem           <= {2'b00, dividend[MAG_WIDTH-1:0]};
            r_q17           <= '0;
            r_b             <= divisor[MAG_WIDTH-1:0];
            r_sign          <= dividend[MAG_WIDTH] ^ divisor[MAG_WIDTH];
            r_dividend_sign <= dividend[MAG_WIDTH];
            r_zero_div      <= (divisor[MAG_WIDTH-1:0] == '0);
            r_ge            <= (dividend[MAG_WIDTH-1:0] >= divisor[MAG_WIDTH-1:0]);
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_q17 <= {r_q17[Q_WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_WIDTH'(DIV_ITERS - 1)) begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_quotient    <= w_result;
          r_saturated   <= w_res_sat;
          r_div_by_zero <= w_res_dbz;
          r_out_valid   <= 1'b1;
          r_state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_fxp_divider.sv
// Self-checking bench for sm_fxp_divider: directed vectors, random ops vs arithmetic model, backpressure, reset.
module tb_sm_fxp_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] dividend;
  logic [16:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] quotient;
  logic        saturated;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  sm_fxp_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .saturated   (saturated),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {div_by_zero, saturated, quotient[16:0]} from plain arithmetic.
  function automatic logic [18:0] ref_div(input logic [16:0] n, input logic [16:0] d);
    longint a, b, q17, mag;
    logic   sgn;
    a   = longint'(n[15:0]);
    b   = longint'(d[15:0]);
    sgn = n[16] ^ d[16];
    if (b == 0) return {1'b1, 1'b0, n[16], 16'hFFFF};
    if (a >= b) return {1'b0, 1'b1, sgn, 16'hFFFF};
    q17 = (a * 131072) / b;
    mag = (q17 + 1) / 2;
    if (mag > 65535) return {1'b0, 1'b1, sgn, 16'hFFFF};
    if (mag == 0) sgn = 1'b0;
    return {1'b0, 1'b0, sgn, mag[15:0]};
  endfunction

  // Drives one operand pair, waits for the result, completes the output handshake.
  // lat counts the cycle starting at the accept edge as cycle 1.
  task automatic do_txn(input logic [16:0] a, input logic [16:0] b,
                        output logic [18:0] got, output int lat);
    int n;
    n        = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    got       = {div_by_zero, saturated, quotient};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 17'h0 ||
        saturated !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b q=%h sat=%b dbz=%b, need 1 0 00000 0 0",
               in_ready, out_valid, quotient, saturated, div_by_zero);
    end
  endtask

  task automatic test_directed;
    logic [16:0] vec_a   [11];
    logic [16:0] vec_b   [11];
    logic [18:0] vec_exp [11];
    logic [18:0] got;
    int          lat;
    vec_a[0]  = 17'h0_4000; vec_b[0]  = 17'h0_8000; vec_exp[0]  = {2'b00, 17'h0_8000};
    vec_a[1]  = 17'h1_4000; vec_b[1]  = 17'h0_8000; vec_exp[1]  = {2'b00, 17'h1_8000};
    vec_a[2]  = 17'h0_0001; vec_b[2]  = 17'h0_0006; vec_exp[2]  = {2'b00, 17'h0_2AAB};
    vec_a[3]  = 17'h0_0001; vec_b[3]  = 17'h0_0003; vec_exp[3]  = {2'b00, 17'h0_5555};
    vec_a[4]  = 17'h1_0000; vec_b[4]  = 17'h0_0005; vec_exp[4]  = {2'b00, 17'h0_0000};
    vec_a[5]  = 17'h0_8000; vec_b[5]  = 17'h1_4000; vec_exp[5]  = {2'b01, 17'h1_FFFF};
    vec_a[6]  = 17'h0_4000; vec_b[6]  = 17'h0_4000; vec_exp[6]  = {2'b01, 17'h0_FFFF};
    vec_a[7]  = 17'h0_FFFE; vec_b[7]  = 17'h0_FFFF; vec_exp[7]  = {2'b00, 17'h0_FFFF};
    vec_a[8]  = 17'h1_1234; vec_b[8]  = 17'h0_0000; vec_exp[8]  = {2'b10, 17'h1_FFFF};
    vec_a[9]  = 17'h0_0000; vec_b[9]  = 17'h1_0000; vec_exp[9]  = {2'b10, 17'h0_FFFF};
    vec_a[10] = 17'h1_0003; vec_b[10] = 17'h1_0008; vec_exp[10] = {2'b00, 17'h0_6000};
    for (int i = 0; i < 11; i++) begin
      do_txn(vec_a[i], vec_b[i], got, lat);
      checks++;
      if (got !== vec_exp[i]) begin
        errors++;
        $display("FAIL directed_%0d: %h/%h got dbz,sat,q=%h need %h", i, vec_a[i], vec_b[i], got, vec_exp[i]);
      end
      checks++;
      if (lat != 19) begin
        errors++;
        $display("FAIL latency_%0d: got %0d cycles need 19", i, lat);
      end
    end
    $display("directed: %0d vectors done", 11);
  endtask

  task automatic test_random;
    logic [16:0] a, b;
    logic [18:0] got, exp;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      b = {1'($urandom_range(1, 0)), 16'($urandom_range(65535, 0))};
      if (i % 10 == 3) b[15:0] = 16'h0;
      a = {1'($urandom_range(1, 0)), 16'($urandom_range(65535, 0))};
      if (i % 4 != 0 && b[15:0] != 0) a[15:0] = 16'($urandom_range(int'(b[15:0]) - 1, 0));
      exp = ref_div(a, b);
      do_txn(a, b, got, lat);
      checks++;
      if (got !== exp || lat != 19) begin
        errors++;
        $display("FAIL random_%0d: %h/%h got dbz,sat,q=%h lat=%0d need %h lat=19", i, a, b, got, lat, exp);
      end
    end
    $display("random: 40 transactions done");
  endtask

  task automatic test_backpressure;
    logic [16:0] a0, b0, a1, b1;
    logic [18:0] exp0, exp1;
    int          lat;
    a0 = 17'h1_0123; b0 = 17'h0_0456;
    a1 = 17'h0_3000; b1 = 17'h1_9000;
    exp0 = ref_div(a0, b0);
    exp1 = ref_div(a1, b1);
    in_valid = 1'b1; dividend = a0; divisor = b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({div_by_zero, saturated, quotient} !== exp0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: got dbz,sat,q=%h ov=%b ir=%b need %h 1 0",
                 i, {div_by_zero, saturated, quotient}, out_valid, in_ready, exp0);
      end
      if (i == 3) begin
        in_valid = 1'b1; dividend = a1; divisor = b1;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: got ov=%b ir=%b need 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_second_accept: got in_ready=%b need 0", in_ready);
    end
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({div_by_zero, saturated, quotient} !== exp1 || lat != 19) begin
      errors++;
      $display("FAIL backpressure_second_result: got %h lat=%0d need %h lat=19",
               {div_by_zero, saturated, quotient}, lat, exp1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("backpressure: held 10 cycles, second pair result %h", {div_by_zero, saturated, quotient});
  endtask

  task automatic test_reset_mid;
    logic [18:0] got;
    int          lat;
    in_valid = 1'b1; dividend = 17'h0_7777; divisor = 17'h0_9999;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got ov=%b ir=%b need 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_txn(17'h0_4000, 17'h0_8000, got, lat);
    checks++;
    if (got !== {2'b00, 17'h0_8000} || lat != 19) begin
      errors++;
      $display("FAIL reset_mid_after: got %h lat=%0d need 008000 lat=19", got, lat);
    end
    $display("reset_mid: fresh transaction result %h latency %0d", got, lat);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
